// File: rtl/platform_update.sv
// Platform bookkeeping for a jump game: judges landings against the current and
// next platforms, scrolls the landed-on platform back to BASE_X and loads a new one.
module platform_update #(
    parameter int unsigned BASE_X      = 40,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned PERFECT_TOL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] new_x,
    input  logic [9:0] new_w,
    input  logic [1:0] new_color,
    input  logic       land_valid,
    input  logic [9:0] land_x,
    input  logic       step,
    input  logic       restart,
    output logic       land_ready,
    output logic [9:0] cur_x,
    output logic [9:0] cur_w,
    output logic [9:0] nxt_x,
    output logic [9:0] nxt_w,
    output logic [1:0] cur_color,
    output logic [1:0] nxt_color,
    output logic [9:0] score,
    output logic [9:0] min,
    output logic [9:0] max,
    output logic       judge_done,
    output logic [1:0] result,
    output logic       game_over
);

    localparam int unsigned W  = 10;
    localparam int unsigned SW = 11;

    localparam logic [1:0] RES_MISS    = 2'b00;
    localparam logic [1:0] RES_STAY    = 2'b01;
    localparam logic [1:0] RES_HIT     = 2'b10;
    localparam logic [1:0] RES_PERFECT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_JUDGE,
        S_SCROLL,
        S_LOAD,
        S_OVER
    } state_t;

    state_t        state;
    logic [W-1:0]  land_q;

    logic [SW-1:0] lx;
    logic [SW-1:0] nxt_end;
    logic [SW-1:0] cur_end;
    logic [SW-1:0] centre;
    logic          in_nxt;
    logic          in_cur;
    logic          perfect;
    logic [SW-1:0] score_inc;
    logic [W-1:0]  score_sat;
    logic [SW-1:0] load_end;
    logic [W-1:0]  load_x;

    // Landing judgement, done in 11 bits so platform ends never wrap.
    always_comb begin
        lx        = SW'(land_q);
        nxt_end   = SW'(nxt_x) + SW'(nxt_w);
        cur_end   = SW'(cur_x) + SW'(cur_w);
        centre    = SW'(nxt_x) + SW'(nxt_w >> 1);
        in_nxt    = (lx >= SW'(nxt_x)) && (lx < nxt_end);
        in_cur    = (lx >= SW'(cur_x)) && (lx < cur_end);
        perfect   = in_nxt && (lx + SW'(PERFECT_TOL) >= centre)
                           && (lx <= centre + SW'(PERFECT_TOL));
        score_inc = SW'(score) + (perfect ? SW'(2) : SW'(1));
        score_sat = (score_inc > SW'(1023)) ? W'(1023) : score_inc[W-1:0];
        load_end  = SW'(new_x) + SW'(new_w);
        load_x    = (load_end > SW'(SCREEN_W))
                    ? W'(SW'(SCREEN_W) - SW'(new_w)) : new_x;
    end

    assign min = cur_x + cur_w;
    assign max = W'(SCREEN_W - 1);

    always_ff @(posedge clk) begin
        judge_done <= 1'b0;
        if (rst || ((state == S_OVER) && restart)) begin
            state      <= S_IDLE;
            land_q     <= '0;
            cur_x      <= W'(BASE_X);
            cur_w      <= W'(60);
            cur_color  <= 2'd0;
            nxt_x      <= W'(200);
            nxt_w      <= W'(60);
            nxt_color  <= 2'd1;
            score      <= '0;
            result     <= RES_MISS;
            land_ready <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (land_valid) begin
                        land_q     <= land_x;
                        state      <= S_JUDGE;
                        land_ready <= 1'b0;
                    end
                end
                S_JUDGE: begin
                    judge_done <= 1'b1;
                    if (in_nxt) begin
                        result    <= perfect ? RES_PERFECT : RES_HIT;
                        score     <= score_sat;
                        cur_x     <= nxt_x;
                        cur_w     <= nxt_w;
                        cur_color <= nxt_color;
                        state     <= S_SCROLL;
                    end else if (in_cur) begin
                        result     <= RES_STAY;
                        state      <= S_IDLE;
                        land_ready <= 1'b1;
                    end else begin
                        result    <= RES_MISS;
                        state     <= S_OVER;
                        game_over <= 1'b1;
                    end
                end
                S_SCROLL: begin
                    if (cur_x <= W'(BASE_X)) begin
                        state <= S_LOAD;
                    end else if (step) begin
                        cur_x <= cur_x - W'(1);
                    end
                end
                S_LOAD: begin
                    nxt_x      <= load_x;
                    nxt_w      <= new_w;
                    nxt_color  <= new_color;
                    state      <= S_IDLE;
                    land_ready <= 1'b1;
                end
                S_OVER: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    land_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_platform_update.sv
// Directed bench for platform_update: landing outcomes, scroll/load sequence,
// clamping, score saturation and reset behaviour.
module tb_platform_update;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] new_x;
    logic [9:0] new_w;
    logic [1:0] new_color;
    logic       land_valid;
    logic [9:0] land_x;
    logic       step;
    logic       restart;
    logic       land_ready;
    logic [9:0] cur_x, cur_w, nxt_x, nxt_w;
    logic [1:0] cur_color, nxt_color;
    logic [9:0] score;
    logic [9:0] min, max;
    logic       judge_done;
    logic [1:0] result;
    logic       game_over;

    int tests  = 0;
    int failed = 0;

    platform_update dut (
        .clk(clk), .rst(rst), .new_x(new_x), .new_w(new_w), .new_color(new_color),
        .land_valid(land_valid), .land_x(land_x), .step(step), .restart(restart),
        .land_ready(land_ready), .cur_x(cur_x), .cur_w(cur_w), .nxt_x(nxt_x),
        .nxt_w(nxt_w), .cur_color(cur_color), .nxt_color(nxt_color), .score(score),
        .min(min), .max(max), .judge_done(judge_done), .result(result),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; land_valid = 1'b0; step = 1'b0; restart = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Pulse land_valid for one edge, then advance through the judge edge.
    task automatic land(input logic [9:0] x);
        land_valid = 1'b1; land_x = x;
        tick();
        land_valid = 1'b0;
        tick();
    endtask

    // Hold step until back in IDLE with the given candidate platform presented.
    task automatic run_to_idle(input logic [9:0] nx, input logic [9:0] nw, input logic [1:0] nc);
        int n;
        new_x = nx; new_w = nw; new_color = nc; step = 1'b1;
        n = 0;
        while (land_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        step = 1'b0;
        tests++;
        if (land_ready !== 1'b1) begin
            failed++;
            $display("FAIL run_to_idle timeout land_ready=%b required 1", land_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (cur_x !== 10'd40 || cur_w !== 10'd60 || cur_color !== 2'd0 ||
            nxt_x !== 10'd200 || nxt_w !== 10'd60 || nxt_color !== 2'd1) begin
            failed++;
            $display("FAIL reset_platforms cur=%0d/%0d/%0d nxt=%0d/%0d/%0d required 40/60/0 200/60/1",
                     cur_x, cur_w, cur_color, nxt_x, nxt_w, nxt_color);
        end
        tests++;
        if (score !== 10'd0 || result !== 2'b00 || judge_done !== 1'b0 ||
            game_over !== 1'b0 || land_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_status score=%0d res=%b jd=%b go=%b lr=%b required 0 00 0 0 1",
                     score, result, judge_done, game_over, land_ready);
        end
        tests++;
        if (min !== 10'd100 || max !== 10'd639) begin
            failed++;
            $display("FAIL reset_window min=%0d max=%0d required 100 639", min, max);
        end
    endtask

    task automatic test_perfect_scroll_load();
        int n;
        do_reset();
        land_valid = 1'b1; land_x = 10'd230;
        tick();
        land_valid = 1'b0;
        tests++;
        if (judge_done !== 1'b0 || land_ready !== 1'b0) begin
            failed++;
            $display("FAIL judge_latency jd=%b lr=%b required 0 0", judge_done, land_ready);
        end
        tick();
        tests++;
        if (judge_done !== 1'b1 || result !== 2'b11 || score !== 10'd2 || cur_x !== 10'd200) begin
            failed++;
            $display("FAIL perfect jd=%b res=%b score=%0d cur_x=%0d required 1 11 2 200",
                     judge_done, result, score, cur_x);
        end
        // Candidate presented during SCROLL must not be taken until LOAD.
        new_x = 10'd123; new_w = 10'd11; new_color = 2'd3;
        step = 1'b1;
        n = 0;
        while (cur_x !== 10'd40 && n < 400) begin
            tick();
            n++;
            if (n == 1) begin
                tests++;
                if (judge_done !== 1'b0 || nxt_x !== 10'd200) begin
                    failed++;
                    $display("FAIL judge_pulse jd=%b nxt_x=%0d required 0 200", judge_done, nxt_x);
                end
            end
        end
        tests++;
        if (n != 160) begin
            failed++;
            $display("FAIL scroll_steps got %0d required 160", n);
        end
        new_x = 10'd400; new_w = 10'd30; new_color = 2'd2;
        tick();
        tick();
        tests++;
        if (nxt_x !== 10'd400 || nxt_w !== 10'd30 || nxt_color !== 2'd2 ||
            land_ready !== 1'b1 || min !== 10'd100 || cur_color !== 2'd1) begin
            failed++;
            $display("FAIL load nxt=%0d/%0d/%0d lr=%b min=%0d cc=%0d required 400/30/2 1 100 1",
                     nxt_x, nxt_w, nxt_color, land_ready, min, cur_color);
        end
        step = 1'b0;
    endtask

    task automatic test_hit();
        do_reset();
        land(10'd205);
        tests++;
        if (result !== 2'b10 || score !== 10'd1 || cur_x !== 10'd200) begin
            failed++;
            $display("FAIL hit res=%b score=%0d cur_x=%0d required 10 1 200", result, score, cur_x);
        end
        do_reset();
        land(10'd259);
        tests++;
        if (result !== 2'b10 || score !== 10'd1) begin
            failed++;
            $display("FAIL hit_last_pixel res=%b score=%0d required 10 1", result, score);
        end
        do_reset();
        land(10'd228);
        tests++;
        if (result !== 2'b11 || score !== 10'd2) begin
            failed++;
            $display("FAIL perfect_edge res=%b score=%0d required 11 2", result, score);
        end
        do_reset();
        land(10'd227);
        tests++;
        if (result !== 2'b10 || score !== 10'd1) begin
            failed++;
            $display("FAIL outside_tol res=%b score=%0d required 10 1", result, score);
        end
    endtask

    task automatic test_stay();
        do_reset();
        land(10'd50);
        tests++;
        if (judge_done !== 1'b1 || result !== 2'b01 || score !== 10'd0 ||
            cur_x !== 10'd40 || nxt_x !== 10'd200) begin
            failed++;
            $display("FAIL stay jd=%b res=%b score=%0d cur_x=%0d nxt_x=%0d required 1 01 0 40 200",
                     judge_done, result, score, cur_x, nxt_x);
        end
        tick();
        tests++;
        if (land_ready !== 1'b1 || judge_done !== 1'b0 || result !== 2'b01) begin
            failed++;
            $display("FAIL stay_ready lr=%b jd=%b res=%b required 1 0 01", land_ready, judge_done, result);
        end
        do_reset();
        land(10'd99);
        tests++;
        if (result !== 2'b01) begin
            failed++;
            $display("FAIL stay_last_pixel res=%b required 01", result);
        end
    endtask

    task automatic test_miss_restart();
        do_reset();
        land(10'd150);
        tests++;
        if (result !== 2'b00 || game_over !== 1'b1 || judge_done !== 1'b1 || land_ready !== 1'b0) begin
            failed++;
            $display("FAIL miss res=%b go=%b jd=%b lr=%b required 00 1 1 0",
                     result, game_over, judge_done, land_ready);
        end
        land(10'd230);
        tests++;
        if (judge_done !== 1'b0 || result !== 2'b00 || score !== 10'd0 ||
            game_over !== 1'b1 || cur_x !== 10'd40) begin
            failed++;
            $display("FAIL over_ignores jd=%b res=%b score=%0d go=%b cur_x=%0d required 0 00 0 1 40",
                     judge_done, result, score, game_over, cur_x);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tests++;
        if (game_over !== 1'b0 || land_ready !== 1'b1 || cur_x !== 10'd40 ||
            nxt_x !== 10'd200 || nxt_color !== 2'd1 || score !== 10'd0) begin
            failed++;
            $display("FAIL restart go=%b lr=%b cur_x=%0d nxt_x=%0d nc=%0d score=%0d required 0 1 40 200 1 0",
                     game_over, land_ready, cur_x, nxt_x, nxt_color, score);
        end
        do_reset();
        land(10'd260);
        tests++;
        if (result !== 2'b00 || game_over !== 1'b1) begin
            failed++;
            $display("FAIL miss_past_nxt res=%b go=%b required 00 1", result, game_over);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        land(10'd230);
        run_to_idle(10'd620, 10'd60, 2'd3);
        tests++;
        if (nxt_x !== 10'd580 || nxt_w !== 10'd60 || nxt_color !== 2'd3) begin
            failed++;
            $display("FAIL clamp nxt=%0d/%0d/%0d required 580/60/3", nxt_x, nxt_w, nxt_color);
        end
        land(10'd610);
        run_to_idle(10'd580, 10'd60, 2'd0);
        tests++;
        if (nxt_x !== 10'd580) begin
            failed++;
            $display("FAIL no_clamp_at_edge nxt_x=%0d required 580", nxt_x);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        land(10'd230);
        run_to_idle(10'd40, 10'd60, 2'd0);
        for (int i = 0; i < 510; i++) begin
            land(10'd70);
            run_to_idle(10'd40, 10'd60, 2'd0);
        end
        tests++;
        if (score !== 10'd1022) begin
            failed++;
            $display("FAIL score_build got %0d required 1022", score);
        end
        land(10'd70);
        tests++;
        if (result !== 2'b11 || score !== 10'd1023) begin
            failed++;
            $display("FAIL saturate res=%b score=%0d required 11 1023", result, score);
        end
        run_to_idle(10'd40, 10'd60, 2'd0);
        land(10'd45);
        tests++;
        if (result !== 2'b10 || score !== 10'd1023) begin
            failed++;
            $display("FAIL saturate_hit res=%b score=%0d required 10 1023", result, score);
        end
    endtask

    task automatic test_reset_mid_scroll();
        do_reset();
        land(10'd230);
        step = 1'b1;
        repeat (5) tick();
        rst = 1'b1; restart = 1'b1; land_valid = 1'b1; land_x = 10'd230;
        tick();
        rst = 1'b0; restart = 1'b0; land_valid = 1'b0; step = 1'b0;
        tests++;
        if (cur_x !== 10'd40 || nxt_x !== 10'd200 || score !== 10'd0 ||
            result !== 2'b00 || land_ready !== 1'b1 || cur_color !== 2'd0) begin
            failed++;
            $display("FAIL mid_scroll_reset cur_x=%0d nxt_x=%0d score=%0d res=%b lr=%b cc=%0d required 40 200 0 00 1 0",
                     cur_x, nxt_x, score, result, land_ready, cur_color);
        end
    endtask

    initial begin
        rst = 1'b1; new_x = '0; new_w = '0; new_color = '0;
        land_valid = 1'b0; land_x = '0; step = 1'b0; restart = 1'b0;
        test_reset();
        test_perfect_scroll_load();
        test_hit();
        test_stay();
        test_miss_restart();
        test_clamp();
        test_saturation();
        test_reset_mid_scroll();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
